key_input_conditioner: RTL and testbench

//  Front end between raw keypad switches (swp0..swp9, sht) and the calculator core.

---
 rtl/key_input_conditioner.sv | 148 ++++++++++++++
 tb/tb_key_input_conditioner.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// Keypad front end: per-switch synchroniser and debouncer, shift-prefix
// resolution, and a one-entry valid/ready token holding register.
module key_input_conditioner #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swp0,
  input  logic       swp1,
  input  logic       swp2,
  input  logic       swp3,
  input  logic       swp4,
  input  logic       swp5,
  input  logic       swp6,
  input  logic       swp7,
  input  logic       swp8,
  input  logic       swp9,
  input  logic       sht,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [3:0] key_digit,
  output logic       key_shift,
  output logic       shift_armed,
  output logic       key_overrun
);

  localparam int unsigned NIN = 11;
  localparam int unsigned SHT = 10;
  localparam int unsigned CW  = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  logic [NIN-1:0] raw_c;
  logic [NIN-1:0] sync1_q, sync2_q;
  logic [NIN-1:0] stable_q, stable_d;
  logic [NIN-1:0] prev_q;
  logic [NIN-1:0] ignore_q, ignore_d;
  logic [NIN-1:0] press_q, press_d;
  logic [CW-1:0]  cnt_q [NIN];
  logic [CW-1:0]  cnt_d [NIN];
  logic [1:0]     warm_q, warm_d;
  logic           warm_c;

  state_t         state_q, state_d;
  logic           valid_q, valid_d;
  logic [3:0]     digit_q, digit_d;
  logic           shift_q, shift_d;
  logic           ovr_q, ovr_d;
  logic           tok_vld;
  logic [3:0]     tok_dig;
  logic           tok_shift;

  assign raw_c = {sht, swp9, swp8, swp7, swp6, swp5, swp4, swp3, swp2, swp1, swp0};

  // Debounce: a level change is taken only after DEBOUNCE consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
        else                      cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  // A switch held through reset stays masked until it is seen released.
  always_comb begin
    warm_d   = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    warm_c   = (warm_q == 2'd2);
    ignore_d = ignore_q & ~(~stable_q & ~sync2_q & {NIN{warm_c}});
    press_d  = stable_q & ~prev_q & ~ignore_q;
  end

  // Shift FSM next state, token formation and holding-register update.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    digit_d   = digit_q;
    shift_d   = shift_q;
    ovr_d     = ovr_q;
    tok_dig   = 4'd0;
    tok_shift = 1'b0;
    tok_vld   = |press_q[9:0];
    for (int i = 9; i >= 0; i--) begin
      if (press_q[i]) tok_dig = 4'(i);
    end
    if (tok_vld) begin
      tok_shift = (state_q == ARMED) ^ press_q[SHT];
      state_d   = IDLE;
    end else if (press_q[SHT]) begin
      state_d = (state_q == IDLE) ? ARMED : IDLE;
    end
    if (valid_q && key_ready) valid_d = 1'b0;
    if (tok_vld) begin
      if (!valid_q || key_ready) begin
        valid_d = 1'b1;
        digit_d = tok_dig;
        shift_d = tok_shift;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      ignore_q <= '1;
      press_q  <= '0;
      cnt_q    <= '{default: '0};
      warm_q   <= 2'd0;
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      digit_q  <= 4'd0;
      shift_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= raw_c;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      ignore_q <= ignore_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      digit_q  <= digit_d;
      shift_q  <= shift_d;
      ovr_q    <= ovr_d;
    end
  end

  assign key_valid   = valid_q;
  assign key_digit   = digit_q;
  assign key_shift   = shift_q;
  assign shift_armed = (state_q == ARMED);
  assign key_overrun = ovr_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Self-checking bench for key_input_conditioner: directed scenarios plus a
// randomized keypad session checked against a token-level reference model.
module tb_key_input_conditioner;

  localparam int D  = 16;
  localparam int RC = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] swp;
  logic       sht;
  logic       key_ready;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_shift;
  logic       shift_armed;
  logic       key_overrun;

  int errors = 0;
  int checks = 0;
  logic [4:0] mon_q[$];

  key_input_conditioner #(.DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst),
    .swp0(swp[0]), .swp1(swp[1]), .swp2(swp[2]), .swp3(swp[3]), .swp4(swp[4]),
    .swp5(swp[5]), .swp6(swp[6]), .swp7(swp[7]), .swp8(swp[8]), .swp9(swp[9]),
    .sht(sht), .key_ready(key_ready),
    .key_valid(key_valid), .key_digit(key_digit), .key_shift(key_shift),
    .shift_armed(shift_armed), .key_overrun(key_overrun)
  );

  always #5 clk = ~clk;

  // Record every accepted token as {shift, digit}.
  always @(posedge clk) begin
    if (!rst && key_valid && key_ready) mon_q.push_back({key_shift, key_digit});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [10:0] m, input int hi, input int lo);
    @(negedge clk);
    {sht, swp} = m;
    repeat (hi) @(negedge clk);
    {sht, swp} = 11'd0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; swp = '0; sht = 1'b0; key_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", key_valid); end
    checks++; if (key_digit !== 4'd0) begin errors++; $display("FAIL reset_digit got=%0d want=0", key_digit); end
    checks++; if (key_shift !== 1'b0) begin errors++; $display("FAIL reset_shift got=%b want=0", key_shift); end
    checks++; if (shift_armed !== 1'b0) begin errors++; $display("FAIL reset_armed got=%b want=0", shift_armed); end
    checks++; if (key_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", key_overrun); end
    @(negedge clk);
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single_press();
    mon_q.delete();
    @(negedge clk);
    swp[8] = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      checks++;
      if (key_valid !== (j == D + 3)) begin
        errors++; $display("FAIL t1_valid_timing edge=%0d got=%b want=%b", j, key_valid, (j == D + 3));
      end
      if (j == D + 3) begin
        checks++;
        if ({key_shift, key_digit} !== 5'h08) begin
          errors++; $display("FAIL t1_token got=%h want=08", {key_shift, key_digit});
        end
      end
    end
    @(negedge clk);
    swp[8] = 1'b0;
    idle(30);
    checks++; if (mon_q.size() != 1) begin errors++; $display("FAIL t1_count got=%0d want=1", mon_q.size()); end
  endtask

  task automatic test_shift_prefix();
    mon_q.delete();
    press(11'h400, 40, 30);
    checks++; if (shift_armed !== 1'b1) begin errors++; $display("FAIL t2_armed got=%b want=1", shift_armed); end
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL t2_sht_no_token got=%0d want=0", mon_q.size()); end
    press(11'h008, 40, 30);
    checks++; if (shift_armed !== 1'b0) begin errors++; $display("FAIL t2_disarm got=%b want=0", shift_armed); end
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== 5'h13) begin
      errors++; $display("FAIL t2_token count=%0d first=%h want 1 x 13", mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 5'h1f);
    end
  endtask

  task automatic test_glitch();
    mon_q.delete();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k % 4 == 0) swp[5] = ~swp[5];
    end
    press(11'h020, 40, 30);
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== 5'h05) begin
      errors++; $display("FAIL t3_glitch count=%0d first=%h want 1 x 05", mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 5'h1f);
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    key_ready = 1'b0;
    press(11'h004, 40, 30);
    checks++; if ({key_valid, key_shift, key_digit} !== 6'h22) begin errors++; $display("FAIL t4_held got=%h want=22", {key_valid, key_shift, key_digit}); end
    checks++; if (key_overrun !== 1'b0) begin errors++; $display("FAIL t4_no_overrun_yet got=%b want=0", key_overrun); end
    press(11'h010, 40, 30);
    checks++; if ({key_valid, key_shift, key_digit} !== 6'h22) begin errors++; $display("FAIL t4_still_held got=%h want=22", {key_valid, key_shift, key_digit}); end
    checks++; if (key_overrun !== 1'b1) begin errors++; $display("FAIL t4_overrun got=%b want=1", key_overrun); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL t4_drain got=%b want=0", key_valid); end
    checks++; if (key_overrun !== 1'b1) begin errors++; $display("FAIL t4_sticky got=%b want=1", key_overrun); end
    idle(3);
    key_ready = 1'b1;
  endtask

  task automatic test_simultaneous();
    mon_q.delete();
    press(11'h082, 40, 30);
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== 5'h01) begin
      errors++; $display("FAIL t5_lowest count=%0d first=%h want 1 x 01", mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 5'h1f);
    end
    press(11'h400, 40, 30);
    checks++; if (shift_armed !== 1'b1) begin errors++; $display("FAIL t5_arm got=%b want=1", shift_armed); end
    press(11'h400, 40, 30);
    checks++; if (shift_armed !== 1'b0) begin errors++; $display("FAIL t5_cancel got=%b want=0", shift_armed); end
    checks++; if (mon_q.size() != 1) begin errors++; $display("FAIL t5_cancel_no_token got=%0d want=1", mon_q.size()); end
  endtask

  task automatic test_same_cycle_shift();
    mon_q.delete();
    press(11'h600, 40, 30);
    checks++; if (shift_armed !== 1'b0) begin errors++; $display("FAIL sc_idle_armed got=%b want=0", shift_armed); end
    press(11'h400, 40, 30);
    press(11'h410, 40, 30);
    checks++; if (shift_armed !== 1'b0) begin errors++; $display("FAIL sc_armed_end got=%b want=0", shift_armed); end
    checks++;
    if (mon_q.size() != 2 || mon_q[0] !== 5'h19 || mon_q[1] !== 5'h04) begin
      errors++; $display("FAIL sc_tokens count=%0d want 2 tokens 19,04", mon_q.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key_ready = 1'b0;
    mon_q.delete();
    press(11'h040, 40, 30);
    press(11'h400, 40, 30);
    checks++; if ({key_valid, shift_armed, key_digit} !== 6'h36) begin errors++; $display("FAIL t6_pre got=%h want=36", {key_valid, shift_armed, key_digit}); end
    @(negedge clk);
    rst = 1'b1;
    swp[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({key_valid, key_digit, key_shift, shift_armed, key_overrun} !== 8'h00) begin
      errors++; $display("FAIL t6_reset got=%h want=00", {key_valid, key_digit, key_shift, shift_armed, key_overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    key_ready = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk);
      #1;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL t6_held_no_token cyc=%0d got=%b want=0", j, key_valid); end
    end
    @(negedge clk);
    swp[0] = 1'b0;
    idle(30);
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL t6_release_no_token got=%0d want=0", mon_q.size()); end
    press(11'h001, 40, 30);
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== 5'h00) begin
      errors++; $display("FAIL t6_repress count=%0d first=%h want 1 x 00", mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 5'h1f);
    end
  endtask

  task automatic test_random();
    logic [10:0] sched [RC];
    logic        rdy   [RC];
    int          arr_t[$];
    logic [4:0]  arr_v[$];
    int          arm_t[$];
    logic        arm_v[$];
    int          t, mode, ng, len, hold, r, d;
    logic [10:0] m;
    logic        ma, mv, ms, mo, mar, acc;
    logic [3:0]  md;
    logic [4:0]  tok;

    @(negedge clk);
    rst = 1'b1; swp = '0; sht = 1'b0; key_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);

    for (int k = 0; k < RC; k++) sched[k] = 11'd0;
    for (int w = 0; w < RC; w += 64) begin
      mode = int'($urandom_range(0, 3));
      for (int k = w; k < w + 64 && k < RC; k++)
        rdy[k] = (mode == 2) ? 1'b0 : (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Build the session: glitches, then a held press, then a settled release.
    t = 0; ma = 1'b0;
    while (t < RC - 200) begin
      r = int'($urandom_range(0, 3));
      m = 11'd0;
      case (r)
        0: m[$urandom_range(0, 9)] = 1'b1;
        1: m[10] = 1'b1;
        2: begin m[$urandom_range(0, 9)] = 1'b1; m[$urandom_range(0, 9)] = 1'b1; end
        default: begin m[10] = 1'b1; m[$urandom_range(0, 9)] = 1'b1; end
      endcase
      ng = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        len = int'($urandom_range(1, D - 1));
        for (int u = 0; u < len; u++) sched[t + u] = m;
        t += len + int'($urandom_range(1, D - 1));
      end
      hold = D + int'($urandom_range(2, 10));
      for (int u = 0; u < hold; u++) sched[t + u] = m;
      if (m[9:0] != 10'd0) begin
        d = 0;
        for (int i = 9; i >= 0; i--) if (m[i]) d = i;
        arr_t.push_back(t + D + 3);
        arr_v.push_back({ma ^ m[10], 4'(d)});
        ma = 1'b0;
      end else begin
        ma = ~ma;
      end
      arm_t.push_back(t + D + 3);
      arm_v.push_back(ma);
      t += hold + D + int'($urandom_range(4, 10));
    end

    mv = 1'b0; md = 4'd0; ms = 1'b0; mo = 1'b0; mar = 1'b0;
    for (int k = 0; k < RC; k++) begin
      @(negedge clk);
      {sht, swp} = sched[k];
      key_ready = rdy[k];
      @(posedge clk);
      acc = mv && rdy[k];
      if (arr_t.size() > 0 && arr_t[0] == k) begin
        tok = arr_v.pop_front();
        void'(arr_t.pop_front());
        if (!mv || acc) begin mv = 1'b1; ms = tok[4]; md = tok[3:0]; end
        else mo = 1'b1;
      end else if (acc) begin
        mv = 1'b0;
      end
      if (arm_t.size() > 0 && arm_t[0] == k) begin
        mar = arm_v.pop_front();
        void'(arm_t.pop_front());
      end
      #1;
      checks++; if (key_valid !== mv) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", k, key_valid, mv); end
      checks++; if ({key_shift, key_digit} !== {ms, md}) begin errors++; $display("FAIL rnd_token cyc=%0d got=%h want=%h", k, {key_shift, key_digit}, {ms, md}); end
      checks++; if (shift_armed !== mar) begin errors++; $display("FAIL rnd_armed cyc=%0d got=%b want=%b", k, shift_armed, mar); end
      checks++; if (key_overrun !== mo) begin errors++; $display("FAIL rnd_overrun cyc=%0d got=%b want=%b", k, key_overrun, mo); end
    end
    @(negedge clk);
    {sht, swp} = 11'd0;
    key_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_shift_prefix();
    test_glitch();
    test_overrun();
    test_simultaneous();
    test_same_cycle_shift();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
